// File: rtl/window_reader.sv
// Reads a window of entries from a circular buffer starting at an offset from its head
// and streams them out as valid/ready beats through a 4-entry queue that absorbs backpressure.
module window_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_offset,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  freeze,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issued;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_done;
    logic                  r_vld_p0;
    logic                  r_vld_p1;
    logic                  r_last_p0;
    logic                  r_last_p1;
    logic [DATA_WIDTH-1:0] r_q_data [4];
    logic [3:0]            r_q_last;
    logic [1:0]            r_wr;
    logic [1:0]            r_rd;
    logic [2:0]            r_cnt;

    logic [2:0] w_occ;
    logic       w_issue;
    logic       w_push;
    logic       w_pop;
    logic       w_last_pop;

    // Reads still in flight are counted against queue space so a stalled sink never overflows it.
    assign w_occ      = r_cnt + {2'b00, r_vld_p0} + {2'b00, r_vld_p1};
    assign w_issue    = (r_state == READ) && (r_issued != r_len) && (w_occ < 3'd4);
    assign w_push     = r_vld_p1;
    assign w_pop      = m_valid && m_ready;
    assign w_last_pop = w_pop && r_q_last[r_rd];

    assign busy    = (r_state != IDLE);
    assign freeze  = busy;
    assign done    = r_done;
    assign rd_addr = r_addr;
    assign m_valid = (r_cnt != 3'd0);
    assign m_data  = r_q_data[r_rd];
    assign m_last  = m_valid && r_q_last[r_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_issued  <= '0;
            r_addr    <= '0;
            r_done    <= 1'b0;
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_last_p0 <= 1'b0;
            r_last_p1 <= 1'b0;
            r_q_last  <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q_data[i] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
            // Read data appears one cycle after its address; tag travels alongside it.
            r_vld_p1  <= r_vld_p0;
            r_last_p1 <= r_last_p0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state   <= READ;
                            r_len     <= length;
                            r_addr    <= start_offset;
                            r_issued  <= LEN_ONE;
                            r_vld_p0  <= 1'b1;
                            r_last_p0 <= (length == LEN_ONE);
                        end
                    end
                end
                READ: begin
                    if (r_issued == r_len) begin
                        r_state <= DRAIN;
                    end else if (w_issue) begin
                        r_addr    <= r_addr + ADDR_ONE;
                        r_issued  <= r_issued + LEN_ONE;
                        r_vld_p0  <= 1'b1;
                        r_last_p0 <= ((r_issued + LEN_ONE) == r_len);
                    end
                end
                DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_push) begin
                r_q_data[r_wr] <= rd_data;
                r_q_last[r_wr] <= r_last_p1;
                r_wr           <= r_wr + 2'd1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_window_reader.sv
// Directed bench for window_reader: a behavioural buffer and expected-beat queue,
// a per-cycle compare process, and literal timing checks for each scenario.
module tb_window_reader;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_offset;
    logic [AW:0]   length;
    logic          busy;
    logic          freeze;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    int total = 0;
    int bad = 0;
    int accepted = 0;
    int done_cnt = 0;

    logic [DW:0]   exp_q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    logic [AW-1:0] s_addr  [0:63];
    logic          s_valid [0:63];
    logic          s_last  [0:63];
    logic          s_done  [0:63];
    logic          s_busy  [0:63];
    logic [DW-1:0] s_data  [0:63];

    always #5 clk = ~clk;

    window_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_offset(start_offset), .length(length),
        .busy(busy), .freeze(freeze), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    function automatic logic [DW-1:0] dval(input int a);
        return 32'hDA7A_0000 + 32'(a * 17 + 3);
    endfunction

    // Circular buffer with a synchronous read port; head fixed at entry 0.
    always @(posedge clk) rd_data <= dval(int'(rd_addr));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_window(input int off, input int len);
        for (int i = 0; i < len; i++)
            exp_q.push_back({1'(i == len - 1), dval((off + i) % N)});
    endtask

    task automatic launch(input int off, input int len, input bit accepted_start);
        start = 1'b1;
        start_offset = off[AW-1:0];
        length = len[AW:0];
        if (accepted_start) model_window(off, len);
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s_addr[k] = rd_addr; s_valid[k] = m_valid; s_last[k] = m_last;
            s_done[k] = done; s_busy[k] = busy; s_data[k] = m_data;
            @(posedge clk); #1;
            if (k == 0) begin
                start = 1'b0;
                start_offset = ~start_offset;
                length = 7'd33;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) chk("done_timeout", done, 1);
    endtask

    initial begin : compare
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                chk("freeze_eq_busy", freeze, busy);
                if (prev_stall) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_data", m_data, prev_data);
                    chk("hold_last", m_last, prev_last);
                end
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_beat", m_valid, 0);
                    end else begin
                        e = exp_q[0];
                        chk("beat_data", m_data, e[DW-1:0]);
                        chk("beat_last", m_last, e[DW]);
                        if (m_ready) begin
                            void'(exp_q.pop_front());
                            accepted++;
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data = m_data;
                prev_last = m_last;
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a0;
        int d0;
        bit seen;
        logic [AW-1:0] addr34 [4];
        logic [DW-1:0] data34 [4];
        addr34 = '{6'd62, 6'd63, 6'd0, 6'd1};
        data34 = '{32'hDA7A_0421, 32'hDA7A_0432, 32'hDA7A_0003, 32'hDA7A_0014};

        rst = 1'b1; start = 1'b0; start_offset = '0; length = '0; m_ready = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_data", m_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic window: offset 5, length 4, sink always ready.
        launch(5, 4, 1);
        capture(9);
        for (int k = 1; k <= 4; k++) chk("t1_addr", s_addr[k], 5 + k - 1);
        for (int k = 0; k < 9; k++) chk("t1_valid", s_valid[k], (k >= 3 && k <= 6));
        chk("t1_data_first", s_data[3], 32'hDA7A_0058);
        chk("t1_data_last", s_data[6], 32'hDA7A_008B);
        chk("t1_last_hi", s_last[6], 1);
        chk("t1_last_lo", s_last[5], 0);
        for (int k = 0; k < 9; k++) chk("t1_done", s_done[k], k == 7);
        for (int k = 0; k < 9; k++) chk("t1_busy", s_busy[k], (k >= 1 && k <= 6));

        // Offset wrap at the top of the buffer.
        launch(62, 4, 1);
        capture(8);
        for (int k = 0; k < 4; k++) chk("t2_addr", s_addr[k + 1], addr34[k]);
        for (int k = 0; k < 4; k++) chk("t2_data", s_data[k + 3], data34[k]);

        // Full buffer with alternating ready.
        a0 = accepted;
        seen = 1'b0;
        launch(10, 64, 1);
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            m_ready = ~m_ready;
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        chk("t3_done_seen", seen, 1);
        chk("t3_beats", accepted - a0, 64);
        chk("t3_model_empty", exp_q.size(), 0);

        // Sink stalled: issue must stop after four reads.
        a0 = accepted;
        m_ready = 1'b0;
        launch(20, 8, 1);
        capture(22);
        chk("t4_addr3", s_addr[3], 22);
        chk("t4_addr4", s_addr[4], 23);
        chk("t4_addr21", s_addr[21], 23);
        chk("t4_valid", s_valid[21], 1);
        chk("t4_head", s_data[21], 32'hDA7A_0157);
        chk("t4_busy", s_busy[21], 1);
        m_ready = 1'b1;
        wait_done(60);
        @(posedge clk); #1;
        chk("t4_beats", accepted - a0, 8);

        // Asynchronous reset mid-window, then a clean window straight after release.
        launch(0, 16, 1);
        capture(4);
        #2;
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("t5_valid", m_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_freeze", freeze, 0);
        chk("t5_last", m_last, 0);
        chk("t5_addr", rd_addr, 0);
        chk("t5_data", m_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        launch(30, 3, 1);
        capture(8);
        chk("t5_new_addr", s_addr[1], 30);
        chk("t5_new_valid2", s_valid[2], 0);
        chk("t5_new_valid3", s_valid[3], 1);
        chk("t5_new_data", s_data[3], dval(30));
        chk("t5_new_done", s_done[6], 1);

        // Zero length, ignored start while busy, and start in the done cycle.
        launch(7, 0, 1);
        capture(4);
        chk("t6_done", s_done[1], 1);
        chk("t6_busy", s_busy[1], 0);
        for (int k = 0; k < 4; k++) chk("t6_novalid", s_valid[k], 0);
        d0 = done_cnt;
        launch(40, 2, 1);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 launch(50, 5, 0);
        @(posedge clk); #1 start = 1'b0;
        wait_done(40);
        launch(12, 3, 1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("t6_restart_busy", busy, 1);
        chk("t6_restart_addr", rd_addr, 12);
        wait_done(40);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_done_count", done_cnt - d0, 2);
        chk("t6_model_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_reader.md
WINDOW_READER -- requirements
Module: window_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of buffer read data and output beats.
REQ-002 Parameter ADDR_WIDTH, default 6: buffer offset width; the window spans at most 2^ADDR_WIDTH entries.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: window request, sampled only when busy is low.
REQ-006 Port start_offset, input, ADDR_WIDTH: first buffer offset from the head pointer.
REQ-007 Port length, input, ADDR_WIDTH+1: number of entries to read, 0..2^ADDR_WIDTH.
REQ-008 Port busy, output, 1: transfer in progress.
REQ-009 Port freeze, output, 1: equals busy; upstream SHALL gate its buffer write enable with it so that the head pointer is stable during a window.
REQ-010 Port done, output, 1: one-cycle completion pulse.
REQ-011 Port rd_addr, output, ADDR_WIDTH: offset to the circular buffer's read address input.
REQ-012 Port rd_data, input, DATA_WIDTH: buffer synchronous read data, valid in the cycle after rd_addr is presented.
REQ-013 Port m_data, output, DATA_WIDTH: output beat data.
REQ-014 Port m_valid, output, 1: output beat valid.
REQ-015 Port m_ready, input, 1: downstream ready.
REQ-016 Port m_last, output, 1: marks the final beat of a window.

Function
REQ-017 FSM states SHALL be IDLE, READ and DRAIN.
- IDLE->READ on start with length>0.
- READ->DRAIN after the last read is issued.
- DRAIN->IDLE on acceptance of the beat with m_last.
REQ-018 start with length=0 SHALL produce done in the next cycle, with no beats and busy remaining low.
REQ-019 start_offset and length SHALL be latched when start is sampled; later input changes SHALL have no effect.
REQ-020 While busy is high, start SHALL be ignored.
REQ-021 Read i (i=0..length-1) SHALL present rd_addr = start_offset + i mod 2^ADDR_WIDTH, wrapping silently.
REQ-022 Each issued read SHALL capture rd_data exactly one cycle later into a 4-entry output queue.
REQ-023 A read SHALL be issued in a cycle only if queue occupancy plus in-flight reads is less than 4, so the queue never overflows under backpressure.
REQ-024 Outside issue cycles, rd_addr SHALL hold its last value.
REQ-025 The output handshake SHALL transfer a beat when m_valid and m_ready are both high.
- m_data, m_last and m_valid SHALL hold stable while m_valid is high and m_ready is low.
REQ-026 m_last SHALL be high only on beat length-1.
REQ-027 Latency: with start high in cycle T and m_ready held high:
- rd_addr = start_offset in cycle T+1;
- first m_valid in cycle T+3;
- one beat per cycle thereafter, with no bubbles.
REQ-028 busy SHALL be high from cycle T+1 through the cycle in which the m_last beat is accepted.
REQ-029 done SHALL pulse in the cycle after the m_last beat is accepted; busy is low in that cycle.
- A new start is accepted in that same cycle.
REQ-030 length = 2^ADDR_WIDTH SHALL read every entry exactly once, ending at offset start_offset-1.

Reset
REQ-031 Asserting rst SHALL immediately force the following, including mid-window; in-flight reads and queued beats are discarded:
- state to IDLE;
- busy, freeze, done, m_valid and m_last to 0;
- rd_addr to 0;
- m_data to 0;
- queue to empty.
REQ-032 After rst deasserts, the first clock edge SHALL treat start as in IDLE.

Verification
REQ-033 ADDR_WIDTH=6, start_offset=5, length=4, m_ready=1 -> rd_addr 5,6,7,8 in cycles T+1..T+4; beats D5..D8 in cycles T+3..T+6; m_last on D8; done in T+7.
REQ-034 start_offset=62, length=4 -> rd_addr 62,63,0,1; data returned in that order.
REQ-035 length=64, offset=10, m_ready toggling 1,0 every cycle -> 64 beats in order D10..D63, D0..D9; no beat lost or duplicated; m_data stable while stalled.
REQ-036 m_ready=0 for 20 cycles after start with length=8 -> exactly 4 reads issued, then issue stalls; releasing m_ready delivers all 8 beats in order.
REQ-037 rst asserted in cycle T+4 of a length-16 window -> m_valid, busy and freeze are 0 asynchronously; a new start after release produces a clean window with no stale beats.
REQ-038 length=0 -> done in T+1, no m_valid; a start pulse during busy is ignored and only one done is produced.
